instruction_decode_fetch: RTL

Upstream neighbour of the execution FSM.
- Fetches instructions from the code ROM and splits them into operation, destination and two source addresses.
- Reads both source rows from data RAM and forwards any in-flight write-back.
- Presents operands and a one-cycle decode-done strobe to the execution unit, then stalls while the execution unit is busy or a branch is pending.

---
 rtl/instruction_decode_fetch.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_decode_fetch.sv
// Fetch/decode front end: reads one instruction from the code ROM, gathers both
// source rows from data RAM (with write-back forwarding) and hands them to the execution unit.
module instruction_decode_fetch #(
    parameter int                OP_W       = 16,
    parameter int                ADDR_W     = 16,
    parameter int                ROM_ADDR_W = 16,
    parameter int                ROW_W      = 96,
    parameter logic [OP_W-1:0]   RETURN_OP  = 16'h0001
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iStart,
    input  logic [ROM_ADDR_W-1:0]     iInitialIp,
    output logic [ROM_ADDR_W-1:0]     oIP,
    input  logic [OP_W+3*ADDR_W-1:0]  iInstruction,
    output logic [ADDR_W-1:0]         oRAMReadAddress0,
    output logic [ADDR_W-1:0]         oRAMReadAddress1,
    input  logic [ROW_W-1:0]          iRAMReadData0,
    input  logic [ROW_W-1:0]          iRAMReadData1,
    input  logic                      iRAMWriteEnable,
    input  logic [ADDR_W-1:0]         iLastDestination,
    input  logic [ROW_W-1:0]          iRAMWriteData,
    input  logic                      iExeBusy,
    input  logic                      iBranchTaken,
    input  logic                      iBranchNotTaken,
    input  logic [ROM_ADDR_W-1:0]     iJumpIp,
    output logic                      oDecodeDone,
    output logic [OP_W-1:0]           oOperation,
    output logic [ADDR_W-1:0]         oDestination,
    output logic [ROW_W-1:0]          oSource0,
    output logic [ROW_W-1:0]          oSource1,
    output logic                      oBusy,
    output logic                      oDone
);

    localparam int INSTR_W = OP_W + 3*ADDR_W;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_FETCH       = 3'd1;
    localparam logic [2:0] S_DECODE      = 3'd2;
    localparam logic [2:0] S_OPERAND     = 3'd3;
    localparam logic [2:0] S_ISSUE       = 3'd4;
    localparam logic [2:0] S_BRANCH_WAIT = 3'd5;
    localparam logic [2:0] S_HALT        = 3'd6;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [ROM_ADDR_W-1:0] ip;

    logic [OP_W-1:0]       op_q;
    logic [ADDR_W-1:0]     dest_q;
    logic [ADDR_W-1:0]     src0_q;
    logic [ADDR_W-1:0]     src1_q;

    logic [ROW_W-1:0]      row0_q;
    logic [ROW_W-1:0]      row1_q;
    logic                  fwd0_q;
    logic                  fwd1_q;

    logic [OP_W-1:0]       instr_op;
    logic [ADDR_W-1:0]     instr_dest;
    logic [ADDR_W-1:0]     instr_src1;
    logic [ADDR_W-1:0]     instr_src0;

    logic                  match0;
    logic                  match1;
    logic [ROW_W-1:0]      row0_next;
    logic [ROW_W-1:0]      row1_next;
    logic                  operand_exit;

    assign instr_op   = iInstruction[INSTR_W-1 -: OP_W];
    assign instr_dest = iInstruction[3*ADDR_W-1 -: ADDR_W];
    assign instr_src1 = iInstruction[2*ADDR_W-1 -: ADDR_W];
    assign instr_src0 = iInstruction[ADDR_W-1:0];

    // ROM and RAM are synchronous, so addresses are presented combinationally in the
    // cycle before the data is needed: ip during FETCH, raw instruction fields during DECODE.
    assign oIP              = ip;
    assign oRAMReadAddress0 = (state == S_DECODE) ? instr_src0 : src0_q;
    assign oRAMReadAddress1 = (state == S_DECODE) ? instr_src1 : src1_q;

    assign oDecodeDone = (state == S_ISSUE);
    assign oBusy       = (state != S_IDLE) && (state != S_HALT);
    assign oDone       = (state == S_HALT);

    // A write-back hitting a source wins over the RAM read; once a source has been
    // forwarded the stale RAM data must never overwrite it again.
    always_comb begin
        match0    = iRAMWriteEnable && (iLastDestination == src0_q);
        match1    = iRAMWriteEnable && (iLastDestination == src1_q);
        row0_next = match0 ? iRAMWriteData : (fwd0_q ? row0_q : iRAMReadData0);
        row1_next = match1 ? iRAMWriteData : (fwd1_q ? row1_q : iRAMReadData1);
    end

    assign operand_exit = (state == S_OPERAND) && !iExeBusy;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:        if (iStart) state_next = S_FETCH;
            S_FETCH:       state_next = S_DECODE;
            S_DECODE:      state_next = S_OPERAND;
            S_OPERAND:     if (!iExeBusy) state_next = S_ISSUE;
            S_ISSUE: begin
                if (op_q == RETURN_OP)
                    state_next = S_HALT;
                else if (op_q[OP_W-1])
                    state_next = S_BRANCH_WAIT;
                else
                    state_next = S_FETCH;
            end
            S_BRANCH_WAIT: if (iBranchTaken || iBranchNotTaken) state_next = S_FETCH;
            S_HALT:        if (iStart) state_next = S_FETCH;
            default:       state_next = S_IDLE;
        endcase
    end

    // Instruction pointer: loaded on start, advanced after a plain instruction or an
    // untaken branch, redirected on a taken branch (taken wins if both are reported).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            ip    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_HALT: begin
                    if (iStart) ip <= iInitialIp;
                end
                S_ISSUE: begin
                    if ((op_q != RETURN_OP) && !op_q[OP_W-1])
                        ip <= ip + ROM_ADDR_W'(1);
                end
                S_BRANCH_WAIT: begin
                    if (iBranchTaken)
                        ip <= iJumpIp;
                    else if (iBranchNotTaken)
                        ip <= ip + ROM_ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_q   <= '0;
            dest_q <= '0;
            src0_q <= '0;
            src1_q <= '0;
        end else if (state == S_DECODE) begin
            op_q   <= instr_op;
            dest_q <= instr_dest;
            src0_q <= instr_src0;
            src1_q <= instr_src1;
        end
    end

    // Forwarded flags are cleared when a new instruction is decoded so each
    // instruction starts from fresh RAM data.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            row0_q <= '0;
            row1_q <= '0;
            fwd0_q <= 1'b0;
            fwd1_q <= 1'b0;
        end else if (state == S_DECODE) begin
            fwd0_q <= 1'b0;
            fwd1_q <= 1'b0;
        end else if (state == S_OPERAND) begin
            row0_q <= row0_next;
            row1_q <= row1_next;
            if (match0) fwd0_q <= 1'b1;
            if (match1) fwd1_q <= 1'b1;
        end
    end

    // Outputs load from the final OPERAND capture and then hold until the next issue.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oOperation   <= '0;
            oDestination <= '0;
            oSource0     <= '0;
            oSource1     <= '0;
        end else if (operand_exit) begin
            oOperation   <= op_q;
            oDestination <= dest_q;
            oSource0     <= row0_next;
            oSource1     <= row1_next;
        end
    end

endmodule
